// File: rtl/acp_tx_packer_if.sv
// ---------------------------------------------------------------------------
// acp_tx_packer_if
//   Write-side bundle between the capture packer and the ACP port of the PS
//   wrapper (acp0_tx_*).
//
//   master : the packer. Drives the burst request, address, ID and beat data.
//   slave  : the ACP port. Accepts the request (rdy) and asks for beats (wdreq).
//
//   acp0_tx_en      burst request, held until a cycle with rdy
//   acp0_tx_rdy     request accepted this cycle
//   acp0_tx_awaddr  burst byte address
//   acp0_tx_awid    constant write ID
//   acp0_tx_wdata   current write beat
//   acp0_tx_wdreq   ACP wants the next beat
// ---------------------------------------------------------------------------
interface acp_tx_packer_if;
    logic        acp0_tx_en;
    logic        acp0_tx_rdy;
    logic [31:0] acp0_tx_awaddr;
    logic [2:0]  acp0_tx_awid;
    logic [63:0] acp0_tx_wdata;
    logic        acp0_tx_wdreq;

    modport master (
        output acp0_tx_en,
        output acp0_tx_awaddr,
        output acp0_tx_awid,
        output acp0_tx_wdata,
        input  acp0_tx_rdy,
        input  acp0_tx_wdreq
    );

    modport slave (
        input  acp0_tx_en,
        input  acp0_tx_awaddr,
        input  acp0_tx_awid,
        input  acp0_tx_wdata,
        output acp0_tx_rdy,
        output acp0_tx_wdreq
    );
endinterface

// File: rtl/acp_tx_packer.sv
// ---------------------------------------------------------------------------
// acp_tx_packer
//   Packs 16-bit ADC samples four at a time into 64-bit words, buffers them in
//   a FIFO and writes them to a linear DDR buffer as fixed-length ACP bursts.
//   A one-cycle irq_done pulse marks completion of the configured burst count.
//
//   clk, rst        clock and asynchronous active-low reset
//   cfg_start       pulse: arm a capture (ignored when cfg_nburst is 0)
//   cfg_stop        pulse: abort (immediately in ARM/REQ, after burst in DATA)
//   cfg_base        DDR byte base address, bits [2:0] ignored
//   cfg_nburst      bursts per capture
//   smp_vld/smp_dat sample stream
//   acp             ACP write channel, master side
//   sts_busy        high whenever the FSM is not IDLE
//   sts_ovf         sticky FIFO overflow
//   sts_bcnt        bursts completed in the current capture
//   irq_done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module acp_tx_packer #(
    parameter int         SMP_W     = 16,
    parameter int         BURST_LEN = 16,
    parameter int         FIFO_AW   = 6,
    parameter logic [2:0] AWID      = 3'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [31:0]           cfg_base,
    input  logic [15:0]           cfg_nburst,
    input  logic                  smp_vld,
    input  logic [SMP_W-1:0]      smp_dat,
    acp_tx_packer_if.master       acp,
    output logic                  sts_busy,
    output logic                  sts_ovf,
    output logic [15:0]           sts_bcnt,
    output logic                  irq_done
);

    localparam int LVL_W  = FIFO_AW + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int WORD_W = 4 * SMP_W;

    localparam logic [LVL_W-1:0]  FULL_LEVEL  = LVL_W'(1 << FIFO_AW);
    localparam logic [LVL_W-1:0]  BURST_LEVEL = LVL_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEATS       = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [31:0]       BURST_BYTES = 32'(BURST_LEN * 8);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        REQ,
        DATA,
        DONE
    } state_t;

    state_t               state;

    logic [WORD_W-1:0]    fifo_mem [1 << FIFO_AW];
    logic [LVL_W-1:0]     wr_ptr;
    logic [LVL_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     fifo_level;

    logic [3*SMP_W-1:0]   pack_buf;
    logic [1:0]           pack_idx;
    logic [BEAT_W-1:0]    beat_cnt;

    logic [31:0]          base_q;
    logic [15:0]          nburst_q;
    logic                 stop_pend;

    logic                 en_q;
    logic [31:0]          awaddr_q;
    logic [63:0]          wdata_q;
    logic                 ovf_q;
    logic [15:0]          bcnt_q;
    logic                 irq_q;

    logic                 pack_active;
    logic                 push;
    logic                 push_ok;
    logic                 pop;
    logic                 fifo_full;
    logic                 last_beat;
    logic [15:0]          bcnt_next;

    // Pointers carry one extra bit so that full and empty are distinguishable
    // from the difference alone.
    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_level == FULL_LEVEL);

    // A word is pushed on every 4th accepted sample. When the FIFO is full the
    // push only survives if a pop frees a slot in the same cycle; otherwise
    // the word is dropped.
    assign pack_active = (state == ARM) || (state == REQ) || (state == DATA);
    assign push        = pack_active && smp_vld && (pack_idx == 2'd3);
    assign push_ok     = push && (!fifo_full || pop);

    // Only the first BURST_LEN wdreqs of a burst pop; beat_cnt saturates at
    // BURST_LEN so trailing wdreqs fall through harmlessly.
    assign pop       = (state == DATA) && acp.acp0_tx_wdreq && (beat_cnt != BEATS);
    assign last_beat = pop && (beat_cnt == LAST_BEAT);
    assign bcnt_next = bcnt_q + 16'd1;

    assign acp.acp0_tx_en     = en_q;
    assign acp.acp0_tx_awaddr = awaddr_q;
    assign acp.acp0_tx_awid   = AWID;
    assign acp.acp0_tx_wdata  = wdata_q;

    assign sts_busy = (state != IDLE);
    assign sts_ovf  = ovf_q;
    assign sts_bcnt = bcnt_q;
    assign irq_done = irq_q;

    // FIFO storage has no reset; validity is tracked entirely by the pointers.
    // On a simultaneous push and pop while full, the write lands in the slot
    // being read, and the read still returns the old contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {smp_dat, pack_buf};
        end
    end

    // Packer, FIFO pointers and the capture FSM. The datapath updates come
    // first and the FSM case last, so a start in IDLE overrides them cleanly
    // (there is no datapath activity in IDLE anyway).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pack_buf  <= '0;
            pack_idx  <= 2'd0;
            beat_cnt  <= '0;
            base_q    <= 32'd0;
            nburst_q  <= 16'd0;
            stop_pend <= 1'b0;
            en_q      <= 1'b0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 64'd0;
            ovf_q     <= 1'b0;
            bcnt_q    <= 16'd0;
            irq_q     <= 1'b0;
        end else begin
            if (pack_active && smp_vld) begin
                case (pack_idx)
                    2'd0:    pack_buf[SMP_W-1:0]         <= smp_dat;
                    2'd1:    pack_buf[2*SMP_W-1:SMP_W]   <= smp_dat;
                    2'd2:    pack_buf[3*SMP_W-1:2*SMP_W] <= smp_dat;
                    default: ;
                endcase
                pack_idx <= pack_idx + 2'd1;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end

            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                wdata_q  <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
                beat_cnt <= beat_cnt + 1'b1;
            end

            irq_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_start && (cfg_nburst != 16'd0)) begin
                        base_q    <= cfg_base & ~32'h7;
                        nburst_q  <= cfg_nburst;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        pack_idx  <= 2'd0;
                        ovf_q     <= 1'b0;
                        bcnt_q    <= 16'd0;
                        stop_pend <= 1'b0;
                        state     <= ARM;
                    end
                end

                ARM: begin
                    if (cfg_stop) begin
                        state <= IDLE;
                    end else if (fifo_level >= BURST_LEVEL) begin
                        en_q     <= 1'b1;
                        awaddr_q <= base_q + 32'(bcnt_q) * BURST_BYTES;
                        state    <= REQ;
                    end
                end

                REQ: begin
                    if (cfg_stop) begin
                        en_q  <= 1'b0;
                        state <= IDLE;
                    end else if (acp.acp0_tx_rdy) begin
                        en_q     <= 1'b0;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (cfg_stop) begin
                        stop_pend <= 1'b1;
                    end
                    // Completion of the configured count wins over a pending
                    // stop, so the final burst still raises irq_done.
                    if (last_beat) begin
                        bcnt_q    <= bcnt_next;
                        stop_pend <= 1'b0;
                        if (bcnt_next == nburst_q) begin
                            irq_q <= 1'b1;
                            state <= DONE;
                        end else if (stop_pend || cfg_stop) begin
                            state <= IDLE;
                        end else begin
                            state <= ARM;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acp_tx_packer.sv
// ---------------------------------------------------------------------------
// tb_acp_tx_packer
//   Self-checking bench for acp_tx_packer. A sample feeder pushes expected
//   64-bit words into a scoreboard queue as it drives samples; an ACP slave
//   model accepts requests, checks addresses and pops the queue for each beat.
// ---------------------------------------------------------------------------
module tb_acp_tx_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        cfg_stop;
    logic [31:0] cfg_base;
    logic [15:0] cfg_nburst;
    logic        smp_vld;
    logic [15:0] smp_dat;
    logic        sts_busy;
    logic        sts_ovf;
    logic [15:0] sts_bcnt;
    logic        irq_done;

    acp_tx_packer_if acp ();

    acp_tx_packer #(
        .SMP_W     (16),
        .BURST_LEN (16),
        .FIFO_AW   (6),
        .AWID      (3'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .cfg_base   (cfg_base),
        .cfg_nburst (cfg_nburst),
        .smp_vld    (smp_vld),
        .smp_dat    (smp_dat),
        .acp        (acp),
        .sts_busy   (sts_busy),
        .sts_ovf    (sts_ovf),
        .sts_bcnt   (sts_bcnt),
        .irq_done   (irq_done)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    logic [31:0] exp_base;
    int          burst_idx;
    int          pass_count  = 0;
    int          check_count = 0;
    int          irq_total   = 0;
    int          irq_mark;

    // Counts cycles with irq_done high; a single pulse per completion shows
    // up as a delta of exactly one.
    always @(negedge clk) begin
        if (irq_done) irq_total++;
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Pulses cfg_start and resets the scoreboard for a new capture.
    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] nburst);
        exp_q.delete();
        exp_base   = base & ~32'h7;
        burst_idx  = 0;
        irq_mark   = irq_total;
        cfg_base   = base;
        cfg_nburst = nburst;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    // Drives one sample per cycle; each completed group of four is pushed to
    // the scoreboard when track is set (first sample in the LSBs).
    task automatic feedSamples(input int count, input logic [15:0] first, input bit track);
        logic [63:0] word;
        word = '0;
        for (int i = 0; i < count; i++) begin
            smp_vld = 1'b1;
            smp_dat = first + 16'(i);
            word[16*(i%4) +: 16] = smp_dat;
            tick();
            if ((i % 4 == 3) && track) exp_q.push_back(word);
        end
        smp_vld = 1'b0;
    endtask

    // ACP slave: waits for a request, checks its address and hold behaviour,
    // accepts it, then issues BURST_LEN wdreqs and checks each beat.
    task automatic serveBurst(input int rdy_wait, input int stop_after, input bit stray);
        int          waited;
        int          stable;
        logic [31:0] exp_addr;
        logic [63:0] last_word;
        waited    = 0;
        stable    = 0;
        last_word = '0;
        if (stray) acp.acp0_tx_wdreq = 1'b1;
        while (!acp.acp0_tx_en && waited < 3000) begin
            tick();
            waited++;
        end
        acp.acp0_tx_wdreq = 1'b0;
        if (!acp.acp0_tx_en) begin
            checkOutput("req_timeout", 64'd0, 64'd1);
            return;
        end
        exp_addr = exp_base + 32'(burst_idx) * 32'd128;
        checkOutput("awaddr", 64'(acp.acp0_tx_awaddr), 64'(exp_addr));
        for (int c = 0; c < rdy_wait; c++) begin
            tick();
            if (acp.acp0_tx_en && acp.acp0_tx_awaddr == exp_addr) stable++;
        end
        if (rdy_wait > 0) checkOutput("req_hold", 64'(stable), 64'(rdy_wait));
        acp.acp0_tx_rdy = 1'b1;
        tick();
        acp.acp0_tx_rdy = 1'b0;
        checkOutput("en_drop", 64'(acp.acp0_tx_en), 64'd0);
        for (int beat = 0; beat < 16; beat++) begin
            acp.acp0_tx_wdreq = 1'b1;
            cfg_stop = (beat == stop_after);
            tick();
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_empty", 64'd0, 64'd1);
            end else begin
                last_word = exp_q.pop_front();
                checkOutput("wdata", acp.acp0_tx_wdata, last_word);
            end
        end
        cfg_stop = 1'b0;
        if (stray) begin
            tick(2);
            checkOutput("wdata_hold", acp.acp0_tx_wdata, last_word);
        end
        acp.acp0_tx_wdreq = 1'b0;
        burst_idx++;
    endtask

    initial begin
        rst               = 1'b0;
        cfg_start         = 1'b0;
        cfg_stop          = 1'b0;
        cfg_base          = 32'd0;
        cfg_nburst        = 16'd0;
        smp_vld           = 1'b0;
        smp_dat           = 16'd0;
        acp.acp0_tx_rdy   = 1'b0;
        acp.acp0_tx_wdreq = 1'b0;
        exp_base          = 32'd0;
        burst_idx         = 0;
        irq_mark          = 0;

        tick(3);
        rst = 1'b1;
        tick();
        checkOutput("rst_en",     64'(acp.acp0_tx_en), 64'd0);
        checkOutput("rst_awaddr", 64'(acp.acp0_tx_awaddr), 64'd0);
        checkOutput("rst_awid",   64'(acp.acp0_tx_awid), 64'd0);
        checkOutput("rst_wdata",  acp.acp0_tx_wdata, 64'd0);
        checkOutput("rst_busy",   64'(sts_busy), 64'd0);
        checkOutput("rst_ovf",    64'(sts_ovf), 64'd0);
        checkOutput("rst_bcnt",   64'(sts_bcnt), 64'd0);
        checkOutput("rst_irq",    64'(irq_done), 64'd0);

        // A start with zero bursts must not leave IDLE.
        applyStimulus(32'h1000_0000, 16'd0);
        tick(3);
        checkOutput("nburst0_busy", 64'(sts_busy), 64'd0);

        // Basic two-burst capture; the second request is held for 10 cycles.
        applyStimulus(32'h1000_0000, 16'd2);
        checkOutput("start_busy", 64'(sts_busy), 64'd1);
        fork
            feedSamples(128, 16'h0000, 1'b1);
            begin
                serveBurst(0, -1, 1'b0);
                serveBurst(10, -1, 1'b0);
            end
        join
        tick(3);
        checkOutput("basic_irq",  64'(irq_total - irq_mark), 64'd1);
        checkOutput("basic_bcnt", 64'(sts_bcnt), 64'd2);
        checkOutput("basic_idle", 64'(sts_busy), 64'd0);
        checkOutput("basic_ovf",  64'(sts_ovf), 64'd0);

        // Unaligned base near the top of memory wraps on the second burst;
        // stray wdreqs outside DATA and beyond the burst must pop nothing.
        applyStimulus(32'hFFFF_FFC7, 16'd2);
        fork
            feedSamples(128, 16'h1000, 1'b1);
            begin
                serveBurst(0, -1, 1'b1);
                serveBurst(0, -1, 1'b1);
            end
        join
        tick(3);
        checkOutput("wrap_irq",  64'(irq_total - irq_mark), 64'd1);
        checkOutput("wrap_bcnt", 64'(sts_bcnt), 64'd2);

        // Stop after the 5th wdreq: burst finishes, no irq, back to IDLE.
        applyStimulus(32'h4000_0000, 16'd3);
        fork
            feedSamples(96, 16'h2000, 1'b1);
            serveBurst(0, 5, 1'b0);
        join
        tick(3);
        checkOutput("stop_data_busy", 64'(sts_busy), 64'd0);
        checkOutput("stop_data_bcnt", 64'(sts_bcnt), 64'd1);
        tick(10);
        checkOutput("stop_data_irq", 64'(irq_total - irq_mark), 64'd0);
        checkOutput("stop_data_en",  64'(acp.acp0_tx_en), 64'd0);

        // Stop while a request is pending drops en on the next cycle.
        applyStimulus(32'h5000_0000, 16'd4);
        feedSamples(64, 16'h3000, 1'b0);
        tick(3);
        checkOutput("req_raised", 64'(acp.acp0_tx_en), 64'd1);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        checkOutput("stop_req_en",   64'(acp.acp0_tx_en), 64'd0);
        checkOutput("stop_req_busy", 64'(sts_busy), 64'd0);

        // Stop while armed returns straight to IDLE.
        applyStimulus(32'h5000_0000, 16'd4);
        feedSamples(8, 16'h3100, 1'b0);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        checkOutput("stop_arm_busy", 64'(sts_busy), 64'd0);

        // Overflow: 64 words fill the FIFO, the 65th push sets sts_ovf and the
        // buffered data still starts at sample 0.
        applyStimulus(32'h2000_0000, 16'd4);
        feedSamples(256, 16'h0000, 1'b1);
        tick(2);
        checkOutput("ovf_full_no_ovf", 64'(sts_ovf), 64'd0);
        feedSamples(44, 16'h0100, 1'b0);
        tick();
        checkOutput("ovf_set", 64'(sts_ovf), 64'd1);
        for (int b = 0; b < 4; b++) serveBurst(0, -1, 1'b0);
        tick(3);
        checkOutput("ovf_irq",    64'(irq_total - irq_mark), 64'd1);
        checkOutput("ovf_bcnt",   64'(sts_bcnt), 64'd4);
        checkOutput("ovf_sticky", 64'(sts_ovf), 64'd1);

        // Asynchronous reset in the middle of a burst.
        applyStimulus(32'h3000_0000, 16'd4);
        feedSamples(280, 16'h0040, 1'b0);
        tick();
        checkOutput("rstdata_ovf", 64'(sts_ovf), 64'd1);
        acp.acp0_tx_rdy = 1'b1;
        tick();
        acp.acp0_tx_rdy   = 1'b0;
        acp.acp0_tx_wdreq = 1'b1;
        tick(3);
        acp.acp0_tx_wdreq = 1'b0;
        checkOutput("rstdata_busy", 64'(sts_busy), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("rstdata_en",     64'(acp.acp0_tx_en), 64'd0);
        checkOutput("rstdata_awaddr", 64'(acp.acp0_tx_awaddr), 64'd0);
        checkOutput("rstdata_wdata",  acp.acp0_tx_wdata, 64'd0);
        checkOutput("rstdata_busy0",  64'(sts_busy), 64'd0);
        checkOutput("rstdata_ovf0",   64'(sts_ovf), 64'd0);
        checkOutput("rstdata_bcnt",   64'(sts_bcnt), 64'd0);
        checkOutput("rstdata_irq",    64'(irq_done), 64'd0);
        tick();
        checkOutput("rstdata_edge_wdata", acp.acp0_tx_wdata, 64'd0);
        rst = 1'b1;
        tick(2);
        checkOutput("rstdata_idle", 64'(sts_busy), 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
